char_sequencer: RTL

Upstream character feeder for the 7-segment animator: captures 7-bit character codes written via a level strobe, buffers them in a small FIFO, and presents them one at a time to the animator's character input with a one-cycle `char_available` pulse. Each character is held for a programmable number of 60 Hz ticks before the next is issued, so characters typed faster than the display can show them are queued instead of lost.

---
 rtl/char_sequencer_if.sv | 41 ++++
 rtl/char_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/char_sequencer_if.sv
// Bus between the character writer, the 7-segment animator and char_sequencer.
// loop_mode is present only when CHAR_SEQ_LOOP_EN is defined.
interface char_sequencer_if;
    logic       ena;
    logic       tick60;
    logic       wr_strobe;
    logic [6:0] wr_char;
    logic       clear;
`ifdef CHAR_SEQ_LOOP_EN
    logic       loop_mode;
`endif
    logic [6:0] char_out;
    logic       char_available;
    logic       fifo_empty;
    logic       fifo_full;
    logic [4:0] level;
    logic       overflow;
    logic [1:0] state_dbg;

    // Handshake: char_available is a one-cycle pulse qualifying a new char_out; there is
    // no ready/backpressure, so the animator must take char_out on the pulse cycle.
`ifdef CHAR_SEQ_LOOP_EN
    modport master (
        output ena, tick60, wr_strobe, wr_char, clear, loop_mode,
        input  char_out, char_available, fifo_empty, fifo_full, level, overflow, state_dbg
    );
    modport slave (
        input  ena, tick60, wr_strobe, wr_char, clear, loop_mode,
        output char_out, char_available, fifo_empty, fifo_full, level, overflow, state_dbg
    );
`else
    modport master (
        output ena, tick60, wr_strobe, wr_char, clear,
        input  char_out, char_available, fifo_empty, fifo_full, level, overflow, state_dbg
    );
    modport slave (
        input  ena, tick60, wr_strobe, wr_char, clear,
        output char_out, char_available, fifo_empty, fifo_full, level, overflow, state_dbg
    );
`endif
endinterface

// File: rtl/char_sequencer.sv
// Buffers strobed 7-bit characters in a circular FIFO and issues one per HOLD_TICKS tick60 pulses.
// Optional CHAR_SEQ_LOOP_EN adds loop_mode: replay the stored characters as a marquee.
module char_sequencer #(
    parameter int DEPTH      = 8,
    parameter int HOLD_TICKS = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    char_sequencer_if.slave  bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_L = 5'(DEPTH);
    localparam logic [7:0]  HOLD_L  = 8'(HOLD_TICKS);

    // state_dbg encoding: 0 IDLE, 1 LOAD, 2 HOLD
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q, sync3_q;
    logic [6:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, play_q, rd_idx;
    logic [4:0]      level_q;
    logic            overflow_q;
    logic [7:0]      tick_cnt_q, tick_inc;
    logic [6:0]      char_q;
    logic            avail_q;
    logic [4:0]      play_nxt;
    logic            strobe_rise, full, empty, push_req, push_ok;
    logic            load_fire, pop, loop_active, hold_done;

`ifdef CHAR_SEQ_LOOP_EN
    assign loop_active = bus.loop_mode;
`else
    assign loop_active = 1'b0;
`endif

    assign strobe_rise = sync2_q & ~sync3_q;
    assign full        = (level_q == DEPTH_L);
    assign empty       = (level_q == 5'd0);
    assign push_req    = strobe_rise & bus.ena & ~bus.clear;
    assign push_ok     = push_req & ~full;
    assign load_fire   = (state_q == LOAD) & bus.ena & ~bus.clear;
    assign pop         = load_fire & ~loop_active;
    assign rd_idx      = rd_ptr_q + play_q;
    assign play_nxt    = 5'(play_q) + 5'd1;
    assign tick_inc    = (tick_cnt_q == 8'hFF) ? 8'hFF : tick_cnt_q + 8'd1;
    assign hold_done   = bus.tick60 & (tick_inc >= HOLD_L);

    // Synchronizer and edge history run even with ena low, so an edge seen while
    // disabled is consumed rather than replayed on re-enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= bus.wr_strobe;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.ena) begin
            if (bus.clear) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (!empty) state_d = LOAD;
                    LOAD:    state_d = HOLD;
                    HOLD:    if (hold_done) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus.wr_char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            play_q     <= '0;
            level_q    <= 5'd0;
            overflow_q <= 1'b0;
        end else if (bus.ena) begin
            if (bus.clear) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                play_q     <= '0;
                level_q    <= 5'd0;
                overflow_q <= 1'b0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (push_req && full) overflow_q <= 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
                level_q <= level_q + 5'(push_ok) - 5'(pop);
                // Play offset is relative to the head and wraps at the current level.
                if (load_fire) begin
                    if (loop_active && (play_nxt < level_q)) play_q <= play_q + AW'(1);
                    else play_q <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= 8'd0;
        end else if (bus.ena) begin
            if (bus.clear || state_q == LOAD) begin
                tick_cnt_q <= 8'd0;
            end else if (state_q == HOLD && bus.tick60) begin
                tick_cnt_q <= tick_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_q  <= 7'd0;
            avail_q <= 1'b0;
        end else begin
            avail_q <= load_fire;
            if (load_fire) char_q <= mem[rd_idx];
        end
    end

    assign bus.char_out       = char_q;
    assign bus.char_available = avail_q;
    assign bus.fifo_empty     = empty;
    assign bus.fifo_full      = full;
    assign bus.level          = level_q;
    assign bus.overflow       = overflow_q;
    assign bus.state_dbg      = state_q;
endmodule
